// File: rtl/sdram_init_refresh_sequencer.sv
// SDRAM power-up init sequencer (PRE, N x AREF, MRS) followed by a periodic
// auto-refresh scheduler that shares the command bus with one user requester.
module sdram_init_refresh_sequencer #(
    parameter int          T_RP_CYC       = 3,
    parameter int          T_RFC_CYC      = 9,
    parameter int          T_MRD_CYC      = 2,
    parameter int          T_REFI_CYC     = 868,
    parameter int          INIT_REFRESHES = 8,
    parameter logic [10:0] MODE_REG       = 11'h020
) (
    input  logic        clk8M,
    input  logic        reset,
    input  logic        sdram_ready,
    input  logic        user_req,
    output logic        user_gnt,
    output logic [3:0]  sdram_cmd,
    output logic [10:0] sdram_a,
    output logic        init_done,
    output logic        refresh_busy,
    output logic        refresh_overrun
);
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;

    localparam int T_MAX01  = (T_RP_CYC > T_RFC_CYC) ? T_RP_CYC : T_RFC_CYC;
    localparam int T_MAX    = (T_MAX01 > T_MRD_CYC) ? T_MAX01 : T_MRD_CYC;
    localparam int TMR_W    = (T_MAX < 2) ? 1 : $clog2(T_MAX);
    localparam int RC_W     = $clog2(INIT_REFRESHES + 1);
    localparam int REFI_W   = $clog2(T_REFI_CYC);

    localparam logic [TMR_W-1:0]  RP_LAST   = TMR_W'(T_RP_CYC - 1);
    localparam logic [TMR_W-1:0]  RFC_LAST  = TMR_W'(T_RFC_CYC - 1);
    localparam logic [TMR_W-1:0]  MRD_LAST  = TMR_W'(T_MRD_CYC - 1);
    localparam logic [RC_W-1:0]   NREF      = RC_W'(INIT_REFRESHES);
    localparam logic [REFI_W-1:0] REFI_LAST = REFI_W'(T_REFI_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_RP, S_WAIT_RFC_INIT, S_WAIT_MRD, S_RUN, S_GRANTED, S_WAIT_RFC
    } state_t;

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [RC_W-1:0]     rcnt_q, rcnt_d;
    logic [REFI_W-1:0]   refi_q, refi_d;
    logic                pend_q, pend_d;
    logic                ovr_q, ovr_d;
    logic [3:0]          cmd_q, cmd_d;
    logic [10:0]         a_q, a_d;
    logic                gnt_q, gnt_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                wrap;

    assign wrap = done_q && (refi_q == REFI_LAST);

    always_comb begin
        state_d = state_q;
        tmr_d   = '0;
        rcnt_d  = rcnt_q;
        refi_d  = '0;
        pend_d  = pend_q;
        ovr_d   = ovr_q;
        cmd_d   = CMD_NOP;
        a_d     = '0;
        gnt_d   = 1'b0;
        done_d  = done_q;
        busy_d  = busy_q;

        if (done_q)
            refi_d = wrap ? '0 : refi_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (sdram_ready) begin
                    cmd_d   = CMD_PRE;
                    a_d     = 11'h400;
                    state_d = S_WAIT_RP;
                end
            end
            S_WAIT_RP: begin
                if (tmr_q == RP_LAST) begin
                    cmd_d   = CMD_AREF;
                    busy_d  = 1'b1;
                    rcnt_d  = RC_W'(1);
                    state_d = S_WAIT_RFC_INIT;
                end else
                    tmr_d = tmr_q + 1'b1;
            end
            S_WAIT_RFC_INIT: begin
                if (tmr_q != RFC_LAST)
                    tmr_d = tmr_q + 1'b1;
                else if (rcnt_q < NREF) begin
                    cmd_d  = CMD_AREF;
                    rcnt_d = rcnt_q + 1'b1;
                end else begin
                    busy_d  = 1'b0;
                    cmd_d   = CMD_MRS;
                    a_d     = MODE_REG;
                    state_d = S_WAIT_MRD;
                end
            end
            S_WAIT_MRD: begin
                if (tmr_q == MRD_LAST) begin
                    done_d  = 1'b1;
                    pend_d  = 1'b0;
                    state_d = S_RUN;
                end else
                    tmr_d = tmr_q + 1'b1;
            end
            S_RUN: begin
                // Refresh wins over a simultaneous user request.
                if (pend_q) begin
                    cmd_d   = CMD_AREF;
                    busy_d  = 1'b1;
                    pend_d  = 1'b0;
                    state_d = S_WAIT_RFC;
                end else if (user_req) begin
                    gnt_d   = 1'b1;
                    state_d = S_GRANTED;
                end
            end
            S_GRANTED: begin
                if (user_req) gnt_d = 1'b1;
                else          state_d = S_RUN;
            end
            S_WAIT_RFC: begin
                if (tmr_q == RFC_LAST) begin
                    busy_d  = 1'b0;
                    state_d = S_RUN;
                end else
                    tmr_d = tmr_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // A wrap coinciding with an AREF issue re-arms pending for the next one.
        if (wrap) begin
            pend_d = 1'b1;
            if (pend_q) ovr_d = 1'b1;
        end

        if (state_q != S_IDLE && !sdram_ready) begin
            state_d = S_IDLE;
            cmd_d   = CMD_NOP;
            a_d     = '0;
            gnt_d   = 1'b0;
            done_d  = 1'b0;
            busy_d  = 1'b0;
            tmr_d   = '0;
            rcnt_d  = '0;
            refi_d  = '0;
            pend_d  = 1'b0;
            ovr_d   = ovr_q;
        end
    end

    always_ff @(posedge clk8M) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            rcnt_q  <= '0;
            refi_q  <= '0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            cmd_q   <= CMD_NOP;
            a_q     <= '0;
            gnt_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rcnt_q  <= rcnt_d;
            refi_q  <= refi_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            cmd_q   <= cmd_d;
            a_q     <= a_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign user_gnt        = gnt_q;
    assign sdram_cmd       = cmd_q;
    assign sdram_a         = a_q;
    assign init_done       = done_q;
    assign refresh_busy    = busy_q;
    assign refresh_overrun = ovr_q;
endmodule

// File: tb/tb_sdram_init_refresh_sequencer.sv
// Directed bench for the SDRAM init/refresh sequencer: init timing, periodic
// refresh, grant handshake, overrun, sdram_ready drop and reset recovery.
module tb_sdram_init_refresh_sequencer;
    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
    localparam logic [3:0] MRS  = 4'b0000;

    logic        clk8M = 1'b0;
    logic        reset, sdram_ready, user_req;
    logic        user_gnt, init_done, refresh_busy, refresh_overrun;
    logic [3:0]  sdram_cmd;
    logic [10:0] sdram_a;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    sdram_init_refresh_sequencer dut (
        .clk8M(clk8M), .reset(reset), .sdram_ready(sdram_ready), .user_req(user_req),
        .user_gnt(user_gnt), .sdram_cmd(sdram_cmd), .sdram_a(sdram_a),
        .init_done(init_done), .refresh_busy(refresh_busy), .refresh_overrun(refresh_overrun)
    );

    always #5 clk8M = ~clk8M;

    task automatic test_reset();
        reset = 1'b1; sdram_ready = 1'b0; user_req = 1'b0;
        repeat (3) @(negedge clk8M);
        checks++;
        if ({sdram_cmd, sdram_a, user_gnt, init_done, refresh_busy, refresh_overrun} !==
            {NOP, 11'h000, 4'b0000}) begin
            failures++;
            $display("FAIL reset: cmd=%b a=%h gnt=%b done=%b busy=%b ovr=%b, want cmd=0111 a=000 flags=0",
                     sdram_cmd, sdram_a, user_gnt, init_done, refresh_busy, refresh_overrun);
        end
    endtask

    // Caller raises sdram_ready during cycle 0; cycles 1..upto are checked.
    task automatic test_init_sequence(input int upto, input bit exp_ovr);
        logic [3:0]  ecmd;
        logic [10:0] ea;
        logic        ebusy, edone;
        for (int c = 1; c <= upto; c++) begin
            @(negedge clk8M); cyc++;
            ecmd = NOP; ea = 11'h000;
            if (c == 1) begin ecmd = PRE; ea = 11'h400; end
            else if (c >= 4 && c <= 67 && (c - 4) % 9 == 0) ecmd = AREF;
            else if (c == 76) begin ecmd = MRS; ea = 11'h020; end
            ebusy = (c >= 4 && c <= 75);
            edone = (c >= 78);
            checks++;
            if ({sdram_cmd, sdram_a, refresh_busy, init_done, user_gnt, refresh_overrun} !==
                {ecmd, ea, ebusy, edone, 1'b0, exp_ovr}) begin
                failures++;
                $display("FAIL init c=%0d: cmd=%b/%b a=%h/%h busy=%b/%b done=%b/%b gnt=%b/0 ovr=%b/%b (got/want)",
                         c, sdram_cmd, ecmd, sdram_a, ea, refresh_busy, ebusy, init_done, edone,
                         user_gnt, refresh_overrun, exp_ovr);
            end
        end
    endtask

    task automatic test_init();
        reset = 1'b0; sdram_ready = 1'b1; cyc = 0;
        test_init_sequence(78, 1'b0);
    endtask

    // Interval wraps make pending visible at 946, 1814, ...; AREF follows one cycle later.
    task automatic test_periodic();
        logic [3:0] ecmd;
        logic       ebusy;
        while (cyc < 1824) begin
            @(negedge clk8M); cyc++;
            ecmd  = (cyc == 947 || cyc == 1815) ? AREF : NOP;
            ebusy = (cyc >= 947 && cyc <= 955) || (cyc >= 1815 && cyc <= 1823);
            checks++;
            if ({sdram_cmd, sdram_a, refresh_busy, init_done, user_gnt} !==
                {ecmd, 11'h000, ebusy, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL periodic c=%0d: cmd=%b/%b busy=%b/%b done=%b/1 gnt=%b/0 a=%h/000",
                         cyc, sdram_cmd, ecmd, refresh_busy, ebusy, init_done, user_gnt, sdram_a);
            end
        end
    endtask

    task automatic test_grant();
        user_req = 1'b1;
        while (cyc < 1835) begin
            @(negedge clk8M); cyc++;
            checks++;
            if ({user_gnt, sdram_cmd} !== {(cyc <= 1830), NOP}) begin
                failures++;
                $display("FAIL grant c=%0d: gnt=%b/%b cmd=%b/0111", cyc, user_gnt, cyc <= 1830, sdram_cmd);
            end
            if (cyc == 1830) user_req = 1'b0;
        end
    endtask

    task automatic test_overrun();
        logic       egnt, eovr, ebusy;
        logic [3:0] ecmd;
        user_req = 1'b1;
        while (cyc < 3846) begin
            @(negedge clk8M); cyc++;
            egnt  = (cyc <= 3835);
            eovr  = (cyc >= 3550);
            ecmd  = (cyc == 3837) ? AREF : NOP;
            ebusy = (cyc >= 3837 && cyc <= 3845);
            checks++;
            if ({user_gnt, refresh_overrun, sdram_cmd, refresh_busy} !== {egnt, eovr, ecmd, ebusy}) begin
                failures++;
                $display("FAIL overrun c=%0d: gnt=%b/%b ovr=%b/%b cmd=%b/%b busy=%b/%b",
                         cyc, user_gnt, egnt, refresh_overrun, eovr, sdram_cmd, ecmd, refresh_busy, ebusy);
            end
            if (cyc == 3835) user_req = 1'b0;
        end
    endtask

    // user_req rises in the cycle the refresh becomes pending: refresh goes first.
    task automatic test_wrap_req();
        logic       egnt, ebusy;
        logic [3:0] ecmd;
        while (cyc < 4432) begin
            @(negedge clk8M); cyc++;
            egnt  = (cyc >= 4429 && cyc <= 4431);
            ecmd  = (cyc == 4419) ? AREF : NOP;
            ebusy = (cyc >= 4419 && cyc <= 4427);
            checks++;
            if ({user_gnt, sdram_cmd, refresh_busy} !== {egnt, ecmd, ebusy}) begin
                failures++;
                $display("FAIL wrap_req c=%0d: gnt=%b/%b cmd=%b/%b busy=%b/%b",
                         cyc, user_gnt, egnt, sdram_cmd, ecmd, refresh_busy, ebusy);
            end
            if (cyc == 4418) user_req = 1'b1;
            if (cyc == 4431) user_req = 1'b0;
        end
    endtask

    task automatic test_ready_drop_run();
        user_req = 1'b1;
        repeat (2) begin
            @(negedge clk8M); cyc++;
            checks++;
            if (user_gnt !== 1'b1) begin
                failures++;
                $display("FAIL drop_run_pre c=%0d: gnt=%b want 1", cyc, user_gnt);
            end
        end
        sdram_ready = 1'b0;
        repeat (2) begin
            @(negedge clk8M); cyc++;
            checks++;
            if ({sdram_cmd, sdram_a, user_gnt, init_done, refresh_busy, refresh_overrun} !==
                {NOP, 11'h000, 4'b0001}) begin
                failures++;
                $display("FAIL drop_run c=%0d: cmd=%b a=%h gnt=%b done=%b busy=%b ovr=%b, want NOP,0,0,0,0,1",
                         cyc, sdram_cmd, sdram_a, user_gnt, init_done, refresh_busy, refresh_overrun);
            end
        end
        user_req = 1'b0;
    endtask

    task automatic test_ready_drop_init();
        sdram_ready = 1'b1;
        test_init_sequence(30, 1'b1);
        sdram_ready = 1'b0;
        repeat (2) begin
            @(negedge clk8M);
            checks++;
            if ({sdram_cmd, sdram_a, init_done, refresh_busy, refresh_overrun} !==
                {NOP, 11'h000, 3'b001}) begin
                failures++;
                $display("FAIL drop_init: cmd=%b a=%h done=%b busy=%b ovr=%b, want NOP,0,0,0,1",
                         sdram_cmd, sdram_a, init_done, refresh_busy, refresh_overrun);
            end
        end
        // Replay with user_req high: no grant may appear until RUN.
        sdram_ready = 1'b1; user_req = 1'b1;
        test_init_sequence(78, 1'b1);
        @(negedge clk8M);
        checks++;
        if ({user_gnt, sdram_cmd} !== {1'b1, NOP}) begin
            failures++;
            $display("FAIL replay_grant: gnt=%b cmd=%b, want gnt=1 cmd=0111", user_gnt, sdram_cmd);
        end
        user_req = 1'b0;
    endtask

    task automatic test_reset_clear();
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk8M);
            checks++;
            if ({sdram_cmd, sdram_a, user_gnt, init_done, refresh_busy, refresh_overrun} !==
                {NOP, 11'h000, 4'b0000}) begin
                failures++;
                $display("FAIL reset_clear: cmd=%b a=%h gnt=%b done=%b busy=%b ovr=%b, want all cleared",
                         sdram_cmd, sdram_a, user_gnt, init_done, refresh_busy, refresh_overrun);
            end
        end
        reset = 1'b0;
        @(negedge clk8M);
        checks++;
        if ({sdram_cmd, sdram_a} !== {PRE, 11'h400}) begin
            failures++;
            $display("FAIL reset_restart: cmd=%b a=%h, want 0010 400", sdram_cmd, sdram_a);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_periodic();
        test_grant();
        test_overrun();
        test_wrap_req();
        test_ready_drop_run();
        test_ready_drop_init();
        test_reset_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
